// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch controller.
package ifetch_pkg;
   localparam int FETCH_ADDR_W = 64;
   localparam int FETCH_INSTR_W = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DROP_ADDR, S_DROP_DATA} fetch_state_e;
   typedef struct packed {
      logic [FETCH_ADDR_W-1:0]  pc;
      logic [FETCH_INSTR_W-1:0] instr;
      logic                     exc;
   } fetch_slot_t;
endpackage

// File: rtl/ifetch_slot.sv
// ifetch_slot: 1-deep registered output buffer between fetch and decode.
module ifetch_slot
   import ifetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic        ready_i,
   input  fetch_slot_t din_i,
   output logic        valid_o,
   output fetch_slot_t dout_o
);
   logic        valid_q;
   fetch_slot_t data_q;
   // a kill wins over both a refill and a drain
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= din_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end
   assign valid_o = valid_q;
   assign dout_o  = data_q;
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC -> ibus request/response FSM feeding a 1-deep slot to decode.
module ifetch_ctrl #(
   parameter int                  ADDR_W    = 64,
   parameter int                  INSTR_W   = 32,
   parameter logic [INSTR_W-1:0]  NOP_INSTR = ifetch_pkg::NOP_INSTR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc_i,
   output logic               pc_stall_o,
   input  logic               flush_i,
   output logic               ireq_valid_o,
   output logic [ADDR_W-1:0]  ireq_addr_o,
   input  logic               iresp_addr_ok_i,
   input  logic               iresp_data_ok_i,
   input  logic [INSTR_W-1:0] iresp_data_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [ADDR_W-1:0]  out_pc_o,
   output logic [INSTR_W-1:0] out_instr_o,
   output logic               out_exc_o
);
   import ifetch_pkg::*;
   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              slot_free, aligned, issue, mis, retire;
   fetch_slot_t       slot_din, slot_dout;
   assign slot_free = !out_valid_o || out_ready_i;
   assign aligned   = pc_i[1:0] == 2'b00;
   assign issue     = !reset && !flush_i && state_q == S_IDLE && slot_free && aligned;
   assign mis       = !reset && !flush_i && state_q == S_IDLE && slot_free && !aligned;
   assign retire    = !reset && !flush_i && iresp_data_ok_i &&
                      (((issue || state_q == S_ADDR) && iresp_addr_ok_i) || state_q == S_DATA);
   // request stays up through a flush until the bus takes it
   assign ireq_valid_o = issue || (!reset && (state_q == S_ADDR || state_q == S_DROP_ADDR));
   assign ireq_addr_o  = issue ? pc_i : req_pc_q;
   assign pc_stall_o   = reset || !(retire || mis || flush_i);
   assign req_pc_d     = issue ? pc_i : req_pc_q;
   assign slot_din     = retire ? '{pc: req_pc_d, instr: iresp_data_i, exc: 1'b0}
                                : '{pc: pc_i, instr: NOP_INSTR, exc: 1'b1};
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:
            if (issue) state_d = !iresp_addr_ok_i ? S_ADDR : iresp_data_ok_i ? S_IDLE : S_DATA;
         S_ADDR, S_DROP_ADDR:
            if (iresp_addr_ok_i)
               state_d = iresp_data_ok_i ? S_IDLE
                       : (flush_i || state_q == S_DROP_ADDR) ? S_DROP_DATA : S_DATA;
            else if (flush_i)
               state_d = S_DROP_ADDR;
         S_DATA, S_DROP_DATA:
            state_d = iresp_data_ok_i ? S_IDLE : flush_i ? S_DROP_DATA : state_q;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
      end
   end
   ifetch_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .load_i  (retire || mis),
      .clear_i (flush_i),
      .ready_i (out_ready_i),
      .din_i   (slot_din),
      .valid_o (out_valid_o),
      .dout_o  (slot_dout)
   );
   assign out_pc_o    = slot_dout.pc;
   assign out_instr_o = slot_dout.instr;
   assign out_exc_o   = slot_dout.exc;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed vectors with a scoreboard popped on slot handshakes.
module tb_ifetch_ctrl;
   import ifetch_pkg::*;
   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pc_i;
   logic        pc_stall_o, flush_i, ireq_valid_o;
   logic [63:0] ireq_addr_o;
   logic        iresp_addr_ok_i, iresp_data_ok_i;
   logic [31:0] iresp_data_i;
   logic        out_valid_o, out_ready_i, out_exc_o;
   logic [63:0] out_pc_o;
   logic [31:0] out_instr_o;
   int          n_vec = 0, n_err = 0;
   fetch_slot_t sb[$];

   always #5 clk = ~clk;

   ifetch_ctrl dut (
      .clk(clk), .reset(reset), .pc_i(pc_i), .pc_stall_o(pc_stall_o), .flush_i(flush_i),
      .ireq_valid_o(ireq_valid_o), .ireq_addr_o(ireq_addr_o),
      .iresp_addr_ok_i(iresp_addr_ok_i), .iresp_data_ok_i(iresp_data_ok_i),
      .iresp_data_i(iresp_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_pc_o(out_pc_o), .out_instr_o(out_instr_o), .out_exc_o(out_exc_o)
   );

   // monitor: every accepted slot must match the oldest expected entry
   always @(negedge clk) begin
      if (!reset && out_valid_o && out_ready_i) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL slot_unexpected: got pc=%h instr=%h exc=%b, expected nothing", out_pc_o, out_instr_o, out_exc_o);
         end else begin
            fetch_slot_t e;
            e = sb.pop_front();
            if (out_pc_o !== e.pc || out_instr_o !== e.instr || out_exc_o !== e.exc) begin
               n_err++;
               $display("FAIL slot_data: got pc=%h instr=%h exc=%b, expected pc=%h instr=%h exc=%b",
                        out_pc_o, out_instr_o, out_exc_o, e.pc, e.instr, e.exc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [63:0] pc, input logic aok, input logic dok,
                        input logic [31:0] data, input logic rdy, input logic fl);
      @(posedge clk);
      #1;
      reset = r; pc_i = pc; iresp_addr_ok_i = aok; iresp_data_ok_i = dok;
      iresp_data_i = data; out_ready_i = rdy; flush_i = fl;
      #1;
   endtask

   task automatic push(input logic [63:0] pc, input logic [31:0] instr, input logic exc);
      fetch_slot_t e;
      e.pc = pc; e.instr = instr; e.exc = exc;
      sb.push_back(e);
   endtask

   initial begin
      reset = 1'b1; pc_i = '0; flush_i = 1'b0; iresp_addr_ok_i = 1'b0;
      iresp_data_ok_i = 1'b0; iresp_data_i = '0; out_ready_i = 1'b0;
      drive(1, 64'h0, 0, 0, 0, 0, 0);
      drive(1, 64'h0, 0, 0, 0, 0, 0);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_ireq_valid", 64'(ireq_valid_o), 64'd0);
      chk("rst_ireq_addr", ireq_addr_o, 64'd0);
      chk("rst_pc_stall", 64'(pc_stall_o), 64'd1);
      chk("rst_out_pc", out_pc_o, 64'd0);
      chk("rst_out_instr", 64'(out_instr_o), 64'd0);
      chk("rst_out_exc", 64'(out_exc_o), 64'd0);
      // zero-wait bus: one instruction per cycle, PC never stalls
      for (int i = 0; i < 3; i++) begin
         drive(0, 64'h8000_0000 + 64'(4 * i), 1, 1, 32'h0000_0100 + 32'(i), 1, 0);
         chk("zw_stall", 64'(pc_stall_o), 64'd0);
         chk("zw_ireq_valid", 64'(ireq_valid_o), 64'd1);
         chk("zw_ireq_addr", ireq_addr_o, 64'h8000_0000 + 64'(4 * i));
         push(64'h8000_0000 + 64'(4 * i), 32'h0000_0100 + 32'(i), 1'b0);
      end
      // addr_ok after 2 wait cycles, data_ok 3 cycles later; pc_i wanders meanwhile
      for (int i = 0; i < 3; i++) begin
         drive(0, (i == 0) ? 64'h8000_0000 : 64'h8000_0040, (i == 2) ? 1'b1 : 1'b0, 0, 0, 1, 0);
         chk("slow_ireq_valid", 64'(ireq_valid_o), 64'd1);
         chk("slow_ireq_addr", ireq_addr_o, 64'h8000_0000);
         chk("slow_stall_addr", 64'(pc_stall_o), 64'd1);
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 64'h8000_0040, 0, 0, 0, 1, 0);
         chk("slow_ireq_idle", 64'(ireq_valid_o), 64'd0);
         chk("slow_stall_data", 64'(pc_stall_o), 64'd1);
      end
      drive(0, 64'h8000_0040, 0, 1, 32'hA5A5_0001, 1, 0);
      chk("slow_retire_stall", 64'(pc_stall_o), 64'd0);
      push(64'h8000_0000, 32'hA5A5_0001, 1'b0);
      // decode back-pressure: slot held, no new request
      for (int i = 0; i < 4; i++) begin
         drive(0, 64'h8000_0004, 0, 0, 0, 0, 0);
         chk("bp_ireq_valid", 64'(ireq_valid_o), 64'd0);
         chk("bp_out_valid", 64'(out_valid_o), 64'd1);
         chk("bp_out_pc", out_pc_o, 64'h8000_0000);
         chk("bp_out_instr", 64'(out_instr_o), 64'hA5A5_0001);
      end
      drive(0, 64'h8000_0004, 1, 0, 0, 1, 0);
      chk("bp_release_ireq", 64'(ireq_valid_o), 64'd1);
      chk("bp_release_addr", ireq_addr_o, 64'h8000_0004);
      // flush in DATA; late response must be discarded
      drive(0, 64'h8000_0004, 0, 0, 0, 1, 1);
      chk("fl_stall", 64'(pc_stall_o), 64'd0);
      drive(0, 64'h8000_1000, 0, 0, 0, 1, 0);
      chk("fl_drop_ireq", 64'(ireq_valid_o), 64'd0);
      chk("fl_drop_stall", 64'(pc_stall_o), 64'd1);
      drive(0, 64'h8000_1000, 0, 1, 32'hDEAD_BEEF, 1, 0);
      chk("fl_drop_data_stall", 64'(pc_stall_o), 64'd1);
      chk("fl_drop_data_ireq", 64'(ireq_valid_o), 64'd0);
      drive(0, 64'h8000_1000, 0, 0, 0, 1, 0);
      chk("fl_out_valid", 64'(out_valid_o), 64'd0);
      chk("fl_new_ireq", 64'(ireq_valid_o), 64'd1);
      chk("fl_new_addr", ireq_addr_o, 64'h8000_1000);
      drive(0, 64'h8000_1000, 1, 0, 0, 1, 0);
      chk("fl_new_hold", ireq_addr_o, 64'h8000_1000);
      // flush coincides with data_ok while decode is not ready
      drive(0, 64'h8000_1000, 0, 1, 32'h1111_2222, 0, 1);
      chk("fl2_stall", 64'(pc_stall_o), 64'd0);
      // misaligned PC: no bus traffic, exception NOP into the slot
      drive(0, 64'h8000_0002, 0, 0, 0, 0, 0);
      chk("fl2_out_valid", 64'(out_valid_o), 64'd0);
      chk("mis_ireq_valid", 64'(ireq_valid_o), 64'd0);
      chk("mis_stall", 64'(pc_stall_o), 64'd0);
      push(64'h8000_0002, 32'h0000_0013, 1'b1);
      drive(0, 64'h8000_2000, 0, 0, 0, 0, 0);
      chk("mis_out_exc", 64'(out_exc_o), 64'd1);
      chk("mis_out_instr", 64'(out_instr_o), 64'h13);
      chk("mis_hold_ireq", 64'(ireq_valid_o), 64'd0);
      drive(0, 64'h8000_2000, 0, 0, 0, 1, 0);
      chk("pre_rst_ireq", 64'(ireq_valid_o), 64'd1);
      // reset while a request is waiting for addr_ok
      drive(1, 64'h8000_2000, 0, 0, 0, 0, 0);
      drive(1, 64'h8000_2000, 0, 0, 0, 0, 0);
      chk("mrst_ireq_valid", 64'(ireq_valid_o), 64'd0);
      chk("mrst_ireq_addr", ireq_addr_o, 64'd0);
      chk("mrst_out_valid", 64'(out_valid_o), 64'd0);
      chk("mrst_out_pc", out_pc_o, 64'd0);
      chk("mrst_out_instr", 64'(out_instr_o), 64'd0);
      chk("mrst_out_exc", 64'(out_exc_o), 64'd0);
      chk("mrst_stall", 64'(pc_stall_o), 64'd1);
      drive(0, 64'h8000_3000, 0, 0, 0, 0, 0);
      chk("post_rst_addr", ireq_addr_o, 64'h8000_3000);
      drive(0, 64'h8000_3000, 0, 0, 0, 0, 0);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
